barcode_serial_reader: RTL and testbench

//   Receive side of the 11-bit barcode: accepts the barcode serially (MSB first, bc[10] first), one bit
//   per accepted beat. Reassembles and validates the word, then decodes it back to the 4-bit number.

---
 rtl/barcode_serial_reader_pkg.sv | 44 ++++
 rtl/barcode_serial_reader_decoder.sv | 27 ++
 rtl/barcode_serial_reader.sv | 149 ++++++++++++++
 tb/tb_barcode_serial_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barcode_serial_reader_pkg.sv
// -----------------------------------------------------------------------------
// barcode_serial_reader_pkg
//   Shared definitions for the 11-bit barcode receive path.
//   Barcode word layout: [10:9] start guard (2'b10), [8:5] number,
//   [4:1] bitwise complement of the number, [0] stop bit (1'b1).
//   Contents: field positions, guard constants, error codes, FSM state
//   encodings and a helper that builds the error code from the check flags.
// -----------------------------------------------------------------------------
package barcode_serial_reader_pkg;

    localparam int BC_W_DEF  = 11;
    localparam int NUM_W_DEF = 4;

    // Field bit positions inside the barcode word
    localparam int START_HI = 10;
    localparam int START_LO = 9;
    localparam int NUM_HI   = 8;
    localparam int NUM_LO   = 5;
    localparam int COMP_HI  = 4;
    localparam int COMP_LO  = 1;
    localparam int STOP_BIT = 0;

    localparam logic [1:0] BC_START = 2'b10;
    localparam logic       BC_STOP  = 1'b1;

    // Error codes; both bits set when guard and complement checks fail together
    localparam logic [1:0] ERR_GUARD = 2'b01;
    localparam logic [1:0] ERR_COMP  = 2'b10;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic [1:0] err_code_f(input logic guard_ok, input logic comp_ok);
        logic [1:0] code;
        code = 2'b00;
        if (!guard_ok) code = code | ERR_GUARD;
        if (!comp_ok)  code = code | ERR_COMP;
        return code;
    endfunction

endpackage

// File: rtl/barcode_serial_reader_decoder.sv
// -----------------------------------------------------------------------------
// barcode_word_decoder
//   Combinational check and decode of one complete barcode word.
//   Ports:
//     i_word      in  BC_W   reassembled barcode word
//     o_num       out NUM_W  number field (meaningful only when both checks pass)
//     o_guard_ok  out 1      start guard and stop bit are correct
//     o_comp_ok   out 1      complement field matches the number field
// -----------------------------------------------------------------------------
module barcode_word_decoder
    import barcode_serial_reader_pkg::*;
#(
    parameter int BC_W  = BC_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic [BC_W-1:0]  i_word,
    output logic [NUM_W-1:0] o_num,
    output logic             o_guard_ok,
    output logic             o_comp_ok
);

    assign o_num      = i_word[NUM_HI:NUM_LO];
    assign o_guard_ok = (i_word[START_HI:START_LO] == BC_START) &&
                        (i_word[STOP_BIT] == BC_STOP);
    assign o_comp_ok  = (i_word[COMP_HI:COMP_LO] == ~i_word[NUM_HI:NUM_LO]);

endmodule

// File: rtl/barcode_serial_reader.sv
// -----------------------------------------------------------------------------
// barcode_serial_reader
//   Receives an 11-bit barcode serially (MSB first), reassembles it, validates
//   the guard/stop bits and the complement field, and presents the decoded
//   4-bit number on a valid/ready interface. Rejected words raise a one-cycle
//   err pulse with a reason code.
//   Optional feature macro: BC_ERR_COUNT_EN adds a saturating rejected-word
//   counter on the err_count port.
//   Ports:
//     clk        in   1          rising-edge clock
//     rst        in   1          asynchronous active-high reset
//     bc_bit     in   1          serial barcode bit
//     bc_valid   in   1          bc_bit valid
//     bc_ready   out  1          reader accepts bc_bit (beat = valid & ready)
//     num        out  NUM_W      decoded number, stable while num_valid
//     num_valid  out  1          decoded number available
//     num_ready  in   1          sink accepts num
//     err        out  1          one-cycle pulse: word rejected
//     err_code   out  2          01 guard/stop, 10 complement, 11 both; 0 when err low
//     err_count  out  ERR_CNT_W  (BC_ERR_COUNT_EN) saturating rejected-word count
// -----------------------------------------------------------------------------
module barcode_serial_reader
    import barcode_serial_reader_pkg::*;
#(
    parameter int BC_W      = BC_W_DEF,
    parameter int NUM_W     = NUM_W_DEF
`ifdef BC_ERR_COUNT_EN
    ,
    parameter int ERR_CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bc_bit,
    input  logic             bc_valid,
    output logic             bc_ready,
    output logic [NUM_W-1:0] num,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             err,
    output logic [1:0]       err_code
`ifdef BC_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    logic [1:0]       r_state;
    logic [BC_W-1:0]  r_shift;
    logic [3:0]       r_bit_cnt;
    logic [NUM_W-1:0] r_num;
    logic             r_num_valid;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic [NUM_W-1:0] w_num;
    logic             w_guard_ok;
    logic             w_comp_ok;
    logic             w_beat;

    barcode_word_decoder #(
        .BC_W  (BC_W),
        .NUM_W (NUM_W)
    ) u_decoder (
        .i_word     (r_shift),
        .o_num      (w_num),
        .o_guard_ok (w_guard_ok),
        .o_comp_ok  (w_comp_ok)
    );

    assign bc_ready  = (r_state == ST_IDLE) || (r_state == ST_SHIFT);
    assign w_beat    = bc_valid && bc_ready;
    assign num       = r_num;
    assign num_valid = r_num_valid;
    assign err       = r_err;
    assign err_code  = r_err_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= 4'd0;
            r_num       <= '0;
            r_num_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            // err/err_code are single-cycle pulses
            r_err      <= 1'b0;
            r_err_code <= 2'b00;

            case (r_state)
                ST_IDLE: begin
                    // Idle line is 0; a 1 is the first start-guard bit
                    if (w_beat && bc_bit) begin
                        r_shift   <= {{(BC_W-1){1'b0}}, 1'b1};
                        r_bit_cnt <= 4'd1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_beat) begin
                        r_shift   <= {r_shift[BC_W-2:0], bc_bit};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(BC_W - 1)) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    r_bit_cnt <= 4'd0;
                    if (w_guard_ok && w_comp_ok) begin
                        r_num       <= w_num;
                        r_num_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= err_code_f(w_guard_ok, w_comp_ok);
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    // ST_HOLD: num is kept after the transfer
                    if (num_ready) begin
                        r_num_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef BC_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    assign err_count = r_err_count;

    // Counts on the same edge that raises err, so it tracks pulses one-for-one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if ((r_state == ST_CHECK) && !(w_guard_ok && w_comp_ok) &&
                     (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_barcode_serial_reader.sv
module tb_barcode_serial_reader;

    typedef struct {
        bit         is_err;
        logic [3:0] num;
        logic [1:0] code;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       bc_bit;
    logic       bc_valid;
    logic       bc_ready;
    logic [3:0] num;
    logic       num_valid;
    logic       num_ready;
    logic       err;
    logic [1:0] err_code;
`ifdef BC_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   cnt_low_en = 0;
    int   low_cnt = 0;

    barcode_serial_reader dut (
        .clk       (clk),
        .rst       (rst),
        .bc_bit    (bc_bit),
        .bc_valid  (bc_valid),
        .bc_ready  (bc_ready),
        .num       (num),
        .num_valid (num_valid),
        .num_ready (num_ready),
        .err       (err),
        .err_code  (err_code)
`ifdef BC_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_num(input logic [3:0] n);
        exp_t e;
        e.is_err = 0; e.num = n; e.code = 2'b00;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] c);
        exp_t e;
        e.is_err = 1; e.num = 4'h0; e.code = c;
        q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the bit is accepted
    task automatic beat(input logic b);
        int t;
        bc_valid = 1'b1;
        bc_bit   = b;
        t = 0;
        while (!bc_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bc_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: bc_ready stuck 0, wanted 1 at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [10:0] w, input logic [10:0] gaps);
        for (int i = 10; i >= 0; i--) begin
            if (gaps[i]) begin
                bc_valid = 1'b0;
                @(posedge clk); #1;
            end
            beat(w[i]);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (num_valid && num_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_num", {28'd0, num}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("num_kind_is_err", 32'(e.is_err), 32'd0);
                    chk("num_value", {28'd0, num}, {28'd0, e.num});
                end
            end
            if (err) begin
                if (q.size() == 0) begin
                    chk("unexpected_err", {30'd0, err_code}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("err_kind_is_err", 32'(e.is_err), 32'd1);
                    chk("err_code", {30'd0, err_code}, {30'd0, e.code});
                end
            end else begin
                chk("err_code_idle", {30'd0, err_code}, 32'd0);
            end
            if (cnt_low_en && !bc_ready) low_cnt++;
        end
    end

    initial begin
        rst = 1'b1; bc_bit = 1'b0; bc_valid = 1'b0; num_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_num", {28'd0, num}, 32'd0);
        chk("rst_num_valid", 32'(num_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_bc_ready", 32'(bc_ready), 32'd1);
`ifdef BC_ERR_COUNT_EN
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: single frame, latency check
        push_num(4'h5);
        send_frame(11'h4B5, 11'h000);
        bc_valid = 1'b0;
        @(negedge clk);
        chk("t1_check_nv", 32'(num_valid), 32'd0);
        chk("t1_check_ready", 32'(bc_ready), 32'd0);
        @(negedge clk);
        chk("t1_hold_nv", 32'(num_valid), 32'd1);
        chk("t1_hold_num", {28'd0, num}, 32'h5);
        chk("t1_hold_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("t1_after_nv", 32'(num_valid), 32'd0);
        chk("t1_after_ready", 32'(bc_ready), 32'd1);
        @(posedge clk); #1;

        // T2: back-to-back frames, bc_ready low 2 cycles per frame
        low_cnt = 0;
        cnt_low_en = 1;
        push_num(4'h0);
        send_frame(11'h41F, 11'h000);
        push_num(4'hF);
        send_frame(11'h5E1, 11'h000);
        push_num(4'hA);
        send_frame(11'h54B, 11'h000);
        bc_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cnt_low_en = 0;
        chk("t2_ready_low_cycles", 32'(low_cnt), 32'd6);

        // T3: rejected words
        push_err(2'b10);
        send_frame(11'h4BD, 11'h000);
        push_err(2'b01);
        send_frame(11'h4B4, 11'h000);
        bc_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_num_unchanged", {28'd0, num}, 32'hA);
        chk("t3_no_nv", 32'(num_valid), 32'd0);
`ifdef BC_ERR_COUNT_EN
        chk("t3_err_count", {24'd0, err_count}, 32'd2);
`endif
        @(posedge clk); #1;

        // T4: sink back-pressure while a new bit is offered
        num_ready = 1'b0;
        push_num(4'h5);
        send_frame(11'h4B5, 11'h000);
        bc_valid = 1'b1;
        bc_bit   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_nv", 32'(num_valid), 32'd1);
            chk("t4_hold_num", {28'd0, num}, 32'h5);
            chk("t4_hold_ready", 32'(bc_ready), 32'd0);
        end
        @(posedge clk); #1;
        num_ready = 1'b1;
        bc_valid  = 1'b0;
        @(posedge clk); #1;
        push_num(4'h0);
        send_frame(11'h41F, 11'h000);
        bc_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // T5: leading idle zeros and gaps inside the frame
        beat(1'b0);
        beat(1'b0);
        beat(1'b0);
        push_num(4'h5);
        send_frame(11'h4B5, 11'b001_0010_0100);
        bc_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // T6: reset mid-frame
        for (int i = 10; i >= 5; i--) beat(bc_word_t6(i));
        bc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(bc_ready), 32'd1);
        chk("t6_rst_nv", 32'(num_valid), 32'd0);
        chk("t6_rst_num", {28'd0, num}, 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_err_code", {30'd0, err_code}, 32'd0);
`ifdef BC_ERR_COUNT_EN
        chk("t6_rst_err_count", {24'd0, err_count}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_num(4'hA);
        send_frame(11'h54B, 11'h000);
        bc_valid = 1'b0;

        for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic bc_word_t6(input int i);
        logic [10:0] w;
        w = 11'h4B5;
        return w[i];
    endfunction

endmodule
